// File: rtl/grf_hazard_pkg.sv
// Shared constants, FSM encoding and scoreboard entry type for the GRF hazard controller.
package grf_hazard_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } sb_entry_t;

  // Tnew saturates at zero once the result exists.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/grf_hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer: down-counter loaded on md_start_e, plus a sticky error flag.
//  state   | meaning
//  MD_IDLE | unit free, waiting for md_start_e
//  MD_BUSY | r_count cycles of mult/div latency remain
module md_busy_timer
  import grf_hazard_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_e,
  input  logic md_is_div_e,
  output logic md_busy,
  output logic md_err
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] W_MULT = CW'(MULT_LAT);
  localparam logic [CW-1:0] W_DIV  = CW'(DIV_LAT);

  md_state_e     r_state;
  logic [CW-1:0] r_count;
  logic          r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (md_start_e) begin
            r_state <= MD_BUSY;
            r_count <= md_is_div_e ? W_DIV : W_MULT;
          end
        end
        MD_BUSY: begin
          // A second start while busy is dropped; only the error records it.
          if (md_start_e) r_err <= 1'b1;
          if (r_count == CW'(1)) begin
            r_state <= MD_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign md_busy = (r_state == MD_BUSY);
  assign md_err  = r_err;

endmodule

// File: rtl/grf_hazard_ctrl.sv
// Decode-stage hazard controller: E/M write scoreboard, forwarding selects,
// stall generation and mult/div busy tracking.
module grf_hazard_ctrl
  import grf_hazard_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [1:0] rs_tuse_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] rt_tuse_d,
  input  logic [4:0] dst_d,
  input  logic [1:0] tnew_d,
  input  logic       md_use_d,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy,
  output logic       md_err
);

  sb_entry_t  r_e;
  sb_entry_t  r_m;
  logic [2:0] w_rs_chk;
  logic [2:0] w_rt_chk;
  logic       w_md_busy;
  logic       w_stall;

  // Returns {hazard, select}; the youngest matching entry decides.
  function automatic logic [2:0] src_check(input logic [4:0] s, input logic [1:0] tuse,
                                           input sb_entry_t e, input sb_entry_t m);
    logic [2:0] r;
    r = {1'b0, FWD_GRF};
    if (s != 5'd0 && tuse != TUSE_NONE) begin
      if (e.dst == s) begin
        if (e.tnew == 2'd0)     r = {1'b0, FWD_E};
        else if (e.tnew > tuse) r = {1'b1, FWD_GRF};
      end else if (m.dst == s) begin
        if (m.tnew == 2'd0)     r = {1'b0, FWD_M};
        else if (m.tnew > tuse) r = {1'b1, FWD_GRF};
      end
    end
    return r;
  endfunction

  assign w_rs_chk = src_check(rs_d, rs_tuse_d, r_e, r_m);
  assign w_rt_chk = src_check(rt_d, rt_tuse_d, r_e, r_m);

  assign w_stall = w_rs_chk[2] | w_rt_chk[2] | (md_use_d & (w_md_busy | md_start_e));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e <= '0;
      r_m <= '0;
    end else begin
      r_m <= '{dst: r_e.dst, tnew: tnew_dec(r_e.tnew)};
      r_e <= w_stall ? '0 : '{dst: dst_d, tnew: tnew_d};
    end
  end

  // The instruction asserting md_start_e is already in E, so a D-stage stall does not hold it back.
  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .clk         (clk),
    .reset       (reset),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .md_busy     (w_md_busy),
    .md_err      (md_err)
  );

  assign stall      = w_stall;
  assign fwd_rs_sel = w_rs_chk[1:0];
  assign fwd_rt_sel = w_rt_chk[1:0];
  assign md_busy    = w_md_busy;

endmodule
